multicycle_ctrl: RTL and testbench

- Multi-cycle control unit that produces the control and operand-select signals consumed by the register-file/mux/ALU datapath: AD1, AD2, AD3, WE3, ALUsrc, ALUctrl, ImmOp.
- Accepts one RV32I instruction per valid/ready handshake, decodes it and sequences it through DECODE, EXEC and WB.
- Samples the datapath's EQ flag to resolve beq/bne and drive pc_src to the PC logic.

---
 rtl/multicycle_ctrl_pkg.sv | 36 +++
 rtl/multicycle_ctrl_imm_gen.sv | 27 ++
 rtl/multicycle_ctrl.sv | 179 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// Consumed by multicycle_ctrl and imm_gen.
package ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Maps the funct3 field shared by R- and I-type ALU ops to {supported, ALUctrl}.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3);
        logic [3:0] r;
        case (f3)
            3'b000:  r = {1'b1, ALU_ADD};
            3'b111:  r = {1'b1, ALU_AND};
            3'b110:  r = {1'b1, ALU_OR};
            3'b010:  r = {1'b1, ALU_SLT};
            default: r = {1'b0, ALU_ADD};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_imm_gen.sv
// Immediate generator: selects and sign-extends the immediate field of the
// instruction register according to its opcode. Purely combinational.
module imm_gen
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] ir_i,
    output logic [DATA_WIDTH-1:0] imm_o
);

    logic [31:0] imm32_s;

    // Pick the immediate format for the opcode; unsupported opcodes give zero.
    always_comb begin
        imm32_s = 32'd0;
        case (ir_i[6:0])
            OP_I:    imm32_s = {{20{ir_i[31]}}, ir_i[31:20]};
            OP_B:    imm32_s = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
            OP_LUI:  imm32_s = {ir_i[31:12], 12'd0};
            default: imm32_s = 32'd0;
        endcase
    end

    assign imm_o = DATA_WIDTH'($signed(imm32_s));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control unit: FETCH -> DECODE -> EXEC -> WB.
// Produces register-file/ALU control for the datapath and resolves beq/bne
// from the live EQ flag. Optional build macro LUI_EN adds lui support; when
// it is undefined opcode 0110111 decodes as illegal.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic                  EQ,
    output logic [ADDR_WIDTH-1:0] AD1,
    output logic [ADDR_WIDTH-1:0] AD2,
    output logic [ADDR_WIDTH-1:0] AD3,
    output logic                  WE3,
    output logic                  ALUsrc,
    output logic [2:0]            ALUctrl,
    output logic [DATA_WIDTH-1:0] ImmOp,
    output logic                  pc_src,
    output logic                  illegal,
    output logic [31:0]           instr_count
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [ADDR_WIDTH-1:0] ad1_q, ad2_q, ad3_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [2:0]            alu_q;
    logic                  alusrc_q, we3_q, illegal_q, is_br_q, is_bne_q;
    logic [31:0]           cnt_q;

    logic [DATA_WIDTH-1:0] imm_s;
    logic                  dec_legal_s, dec_alusrc_s, dec_br_s, dec_bne_s;
    logic [2:0]            dec_alu_s;
    logic [ADDR_WIDTH-1:0] dec_ad1_s;
    logic [3:0]            fn_s;
    logic                  ready_s, pc_src_s;

    imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
        .ir_i  (ir_q),
        .imm_o (imm_s)
    );

    assign fn_s = alu_from_funct3(ir_q[14:12]);

    // Decode the held instruction into legality and ALU controls.
    always_comb begin
        dec_legal_s  = 1'b0;
        dec_alu_s    = ALU_ADD;
        dec_alusrc_s = 1'b0;
        dec_br_s     = 1'b0;
        dec_bne_s    = 1'b0;
        dec_ad1_s    = ADDR_WIDTH'(ir_q[19:15]);
        case (ir_q[6:0])
            OP_R: begin
                if (ir_q[31:25] == 7'b0000000 && fn_s[3]) begin
                    dec_legal_s = 1'b1;
                    dec_alu_s   = fn_s[2:0];
                end else if (ir_q[31:25] == 7'b0100000 && ir_q[14:12] == 3'b000) begin
                    dec_legal_s = 1'b1;
                    dec_alu_s   = ALU_SUB;
                end else begin
                    dec_legal_s = 1'b0;
                end
            end
            OP_I: begin
                if (fn_s[3]) begin
                    dec_legal_s  = 1'b1;
                    dec_alu_s    = fn_s[2:0];
                    dec_alusrc_s = 1'b1;
                end else begin
                    dec_legal_s = 1'b0;
                end
            end
            OP_B: begin
                if (ir_q[14:13] == 2'b00) begin
                    dec_legal_s = 1'b1;
                    dec_br_s    = 1'b1;
                    dec_bne_s   = ir_q[12];
                    dec_alu_s   = ALU_SUB;
                end else begin
                    dec_legal_s = 1'b0;
                end
            end
`ifdef LUI_EN
            OP_LUI: begin
                dec_legal_s  = 1'b1;
                dec_alusrc_s = 1'b1;
                dec_alu_s    = ALU_ADD;
                dec_ad1_s    = '0;
            end
`endif
            default: dec_legal_s = 1'b0;
        endcase
    end

    // Next-state and combinational handshake / branch outputs.
    always_comb begin
        state_d  = state_q;
        ready_s  = 1'b0;
        pc_src_s = 1'b0;
        case (state_q)
            FETCH: begin
                ready_s = 1'b1;
                if (instr_valid) state_d = DECODE;
                else             state_d = FETCH;
            end
            DECODE: begin
                if (dec_legal_s) state_d = EXEC;
                else             state_d = FETCH;
            end
            EXEC: begin
                if (is_br_q) begin
                    pc_src_s = is_bne_q ? ~EQ : EQ;
                    state_d  = FETCH;
                end else begin
                    state_d  = WB;
                end
            end
            WB:      state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // State, instruction register, decoded controls and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            ad1_q     <= '0;
            ad2_q     <= '0;
            ad3_q     <= '0;
            imm_q     <= '0;
            alu_q     <= 3'd0;
            alusrc_q  <= 1'b0;
            we3_q     <= 1'b0;
            illegal_q <= 1'b0;
            is_br_q   <= 1'b0;
            is_bne_q  <= 1'b0;
            cnt_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && instr_valid) ir_q <= instr;
            // Illegal decodes leave the datapath controls untouched.
            if (state_q == DECODE && dec_legal_s) begin
                ad1_q    <= dec_ad1_s;
                ad2_q    <= ADDR_WIDTH'(ir_q[24:20]);
                ad3_q    <= ADDR_WIDTH'(ir_q[11:7]);
                imm_q    <= imm_s;
                alu_q    <= dec_alu_s;
                alusrc_q <= dec_alusrc_s;
                is_br_q  <= dec_br_s;
                is_bne_q <= dec_bne_s;
            end
            illegal_q <= (state_q == DECODE) && !dec_legal_s;
            // Writes to x0 retire without a register-file write.
            we3_q     <= (state_q == EXEC) && !is_br_q && (ad3_q != '0);
            if ((state_q == EXEC && is_br_q) || state_q == WB) cnt_q <= cnt_q + 32'd1;
        end
    end

    assign instr_ready = ready_s;
    assign pc_src      = pc_src_s;
    assign AD1         = ad1_q;
    assign AD2         = ad2_q;
    assign AD3         = ad3_q;
    assign WE3         = we3_q;
    assign ALUsrc      = alusrc_q;
    assign ALUctrl     = alu_q;
    assign ImmOp       = imm_q;
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instructions followed by
// randomized instructions compared against a behavioural decode model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        EQ = 1'b0;
    logic [4:0]  AD1, AD2, AD3;
    logic        WE3, ALUsrc, pc_src, illegal;
    logic [2:0]  ALUctrl;
    logic [31:0] ImmOp, instr_count;

    int total  = 0;
    int passed = 0;

    multicycle_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .EQ(EQ), .AD1(AD1), .AD2(AD2), .AD3(AD3),
        .WE3(WE3), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .ImmOp(ImmOp),
        .pc_src(pc_src), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        legal;
        bit        br;
        bit        bne;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] imm;
        bit        alusrc;
        bit [2:0]  alu;
        bit        use_imm;
        bit        use_rs2;
    } exp_t;

    // Model of what the datapath controls should currently hold.
    logic [4:0]  m_ad1 = 5'd0, m_ad2 = 5'd0, m_ad3 = 5'd0;
    logic [31:0] m_imm = 32'd0, m_count = 32'd0;
    logic        m_alusrc = 1'b0;
    logic [2:0]  m_alu = 3'd0;
    bit          ad2_known = 1'b1, imm_known = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Reference decode written from the ISA rules, not the RTL structure.
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        int   b;
        e = '{default: 0};
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        if (w[6:0] == 7'h33) begin
            e.use_rs2 = 1'b1;
            e.legal   = 1'b1;
            if      (w[31:25] == 7'h00 && w[14:12] == 3'd0) e.alu = 3'd0;
            else if (w[31:25] == 7'h20 && w[14:12] == 3'd0) e.alu = 3'd1;
            else if (w[31:25] == 7'h00 && w[14:12] == 3'd7) e.alu = 3'd2;
            else if (w[31:25] == 7'h00 && w[14:12] == 3'd6) e.alu = 3'd3;
            else if (w[31:25] == 7'h00 && w[14:12] == 3'd2) e.alu = 3'd5;
            else e.legal = 1'b0;
        end else if (w[6:0] == 7'h13) begin
            e.use_imm = 1'b1;
            e.alusrc  = 1'b1;
            e.imm     = 32'($signed(w) >>> 20);
            e.legal   = 1'b1;
            if      (w[14:12] == 3'd0) e.alu = 3'd0;
            else if (w[14:12] == 3'd7) e.alu = 3'd2;
            else if (w[14:12] == 3'd6) e.alu = 3'd3;
            else if (w[14:12] == 3'd2) e.alu = 3'd5;
            else e.legal = 1'b0;
        end else if (w[6:0] == 7'h63) begin
            e.legal   = (w[14:12] == 3'd0) || (w[14:12] == 3'd1);
            e.br      = 1'b1;
            e.bne     = (w[14:12] == 3'd1);
            e.alu     = 3'd1;
            e.use_imm = 1'b1;
            e.use_rs2 = 1'b1;
            b = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            if (w[31]) b = b - 8192;
            e.imm = 32'(b);
        end else if (w[6:0] == 7'h37) begin
`ifdef LUI_EN
            e.legal = 1'b1;
`else
            e.legal = 1'b0;
`endif
            e.rs1     = 5'd0;
            e.alusrc  = 1'b1;
            e.alu     = 3'd0;
            e.use_imm = 1'b1;
            e.imm     = w & 32'hFFFF_F000;
        end else begin
            e.legal = 1'b0;
        end
        return e;
    endfunction

    // Offer one instruction in FETCH and follow it through every stage.
    task automatic run_instr(input logic [31:0] w, input logic eq);
        exp_t e;
        e = ref_decode(w);
        chk("ready_fetch", 32'(instr_ready), 32'd1);
        instr = w;
        instr_valid = 1'b1;
        EQ = 1'b0;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr = $urandom;
        chk("ready_decode", 32'(instr_ready), 32'd0);
        chk("we3_decode", 32'(WE3), 32'd0);
        chk("pc_src_decode", 32'(pc_src), 32'd0);
        @(negedge clk);
        if (!e.legal) begin
            chk("illegal_pulse", 32'(illegal), 32'd1);
            chk("ready_after_illegal", 32'(instr_ready), 32'd1);
            chk("we3_illegal", 32'(WE3), 32'd0);
            chk("ad1_held", 32'(AD1), 32'(m_ad1));
            chk("ad3_held", 32'(AD3), 32'(m_ad3));
            chk("alusrc_held", 32'(ALUsrc), 32'(m_alusrc));
            chk("aluctrl_held", 32'(ALUctrl), 32'(m_alu));
            if (ad2_known) chk("ad2_held", 32'(AD2), 32'(m_ad2));
            if (imm_known) chk("imm_held", ImmOp, m_imm);
            chk("count_illegal", instr_count, m_count);
            @(negedge clk);
            chk("illegal_one_cycle", 32'(illegal), 32'd0);
        end else begin
            m_ad1 = e.rs1; m_ad3 = e.rd; m_alusrc = e.alusrc; m_alu = e.alu;
            ad2_known = e.use_rs2; imm_known = e.use_imm;
            if (e.use_rs2) m_ad2 = e.rs2;
            if (e.use_imm) m_imm = e.imm;
            chk("ad1", 32'(AD1), 32'(e.rs1));
            chk("ad3", 32'(AD3), 32'(e.rd));
            chk("alusrc", 32'(ALUsrc), 32'(e.alusrc));
            chk("aluctrl", 32'(ALUctrl), 32'(e.alu));
            if (e.use_rs2) chk("ad2", 32'(AD2), 32'(e.rs2));
            if (e.use_imm) chk("immop", ImmOp, e.imm);
            chk("illegal_low", 32'(illegal), 32'd0);
            chk("ready_exec", 32'(instr_ready), 32'd0);
            EQ = eq;
            #1;
            chk("pc_src_exec", 32'(pc_src), e.br ? 32'(e.bne ? !eq : eq) : 32'd0);
            @(negedge clk);
            EQ = 1'b0;
            if (e.br) begin
                m_count = m_count + 32'd1;
                chk("ready_after_branch", 32'(instr_ready), 32'd1);
                chk("we3_branch", 32'(WE3), 32'd0);
                chk("pc_src_after", 32'(pc_src), 32'd0);
                chk("count_branch", instr_count, m_count);
            end else begin
                chk("we3_wb", 32'(WE3), 32'(e.rd != 5'd0));
                chk("ad3_wb", 32'(AD3), 32'(e.rd));
                chk("ready_wb", 32'(instr_ready), 32'd0);
                @(negedge clk);
                m_count = m_count + 32'd1;
                chk("we3_after_wb", 32'(WE3), 32'd0);
                chk("ready_after_wb", 32'(instr_ready), 32'd1);
                chk("count_wb", instr_count, m_count);
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [2:0]  f3;
        logic [9:0]  rf [5];
        r = $urandom;
        rf[0] = 10'b0000000_000; rf[1] = 10'b0100000_000; rf[2] = 10'b0000000_111;
        rf[3] = 10'b0000000_110; rf[4] = 10'b0000000_010;
        case ($urandom_range(0, 5))
            0: begin
                f3 = rf[$urandom_range(0, 4)][2:0];
                return {rf[$urandom_range(0, 4)][9:3] & 7'h20, r[24:15], f3, r[11:7], 7'h33};
            end
            1: begin
                f3 = 3'($urandom_range(0, 3));
                f3 = (f3 == 3'd0) ? 3'd0 : (f3 == 3'd1) ? 3'd7 : (f3 == 3'd2) ? 3'd6 : 3'd2;
                return {r[31:15], f3, r[11:7], 7'h13};
            end
            2:       return {r[31:13], 1'b0, r[11:7], 7'h63} & ~32'h0000_4000;
            3:       return {r[31:7], 7'h37};
            4:       return {r[31:15], 3'($urandom_range(0, 7)), r[11:7], 7'h33};
            default: return r;
        endcase
    endfunction

    int accepts[$];

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_we3", 32'(WE3), 32'd0);
        chk("rst_imm", ImmOp, 32'd0);
        chk("rst_count", instr_count, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);

        run_instr(32'h0050_0513, 1'b0);   // addi x10,x0,5
        run_instr(32'h4020_81B3, 1'b0);   // sub x3,x1,x2
        run_instr(32'h0020_81B3, 1'b0);   // add x3,x1,x2
        run_instr(32'hFE20_9CE3, 1'b0);   // bne taken
        run_instr(32'hFE20_9CE3, 1'b1);   // bne not taken
        run_instr(32'hFE20_8CE3, 1'b1);   // beq taken
        run_instr(32'h0010_0013, 1'b0);   // addi x0,x0,1
        run_instr(32'hFFFF_FFFF, 1'b0);   // illegal
        run_instr(32'h1234_52B7, 1'b0);   // lui x5,0x12345
        run_instr(32'h4020_F1B3, 1'b0);   // and with sub funct7: illegal

        // Reset in EXEC aborts the write.
        instr = 32'h0050_0513;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ad1 = 5'd0; m_ad2 = 5'd0; m_ad3 = 5'd0; m_imm = 32'd0;
        m_alusrc = 1'b0; m_alu = 3'd0; m_count = 32'd0;
        ad2_known = 1'b1; imm_known = 1'b1;
        chk("abort_we3", 32'(WE3), 32'd0);
        chk("abort_ready", 32'(instr_ready), 32'd1);
        chk("abort_ad1", 32'(AD1), 32'd0);
        chk("abort_ad3", 32'(AD3), 32'd0);
        chk("abort_imm", ImmOp, 32'd0);
        chk("abort_alusrc", 32'(ALUsrc), 32'd0);
        chk("abort_count", instr_count, 32'd0);
        @(negedge clk);
        chk("abort_we3_late", 32'(WE3), 32'd0);

        // Back-to-back requests are accepted every fourth cycle.
        instr = 32'h0010_8093;
        instr_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (instr_ready) accepts.push_back(c);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("stream_accepts", 32'(accepts.size()), 32'd5);
        for (int i = 1; i < accepts.size(); i++)
            chk("stream_spacing", 32'(accepts[i] - accepts[i-1]), 32'd4);
        m_count = m_count + 32'd5;
        m_ad1 = 5'd1; m_ad3 = 5'd1; m_imm = 32'd1; m_alusrc = 1'b1; m_alu = 3'd0;
        ad2_known = 1'b0; imm_known = 1'b1;
        chk("stream_count", instr_count, m_count);

        for (int n = 0; n < 60; n++)
            run_instr(rand_instr(), 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
